// File: rtl/dmem_rmw_port.sv
// Data-memory port adapter: forwards loads and full-word stores to a synchronous-read
// word memory and turns partial stores into a read-modify-write pair of cycles.
module dmem_rmw_port (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] addr_IN,
  input  logic [31:0] wdata_IN,
  input  logic [1:0]  size_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  output logic [31:0] rdata_OUT,
  output logic        stall_OUT,
  output logic        err_OUT,
  output logic [31:0] mem_addr_OUT,
  output logic        mem_rd_OUT,
  output logic        mem_wr_OUT,
  output logic [31:0] mem_wdata_OUT,
  input  logic [31:0] mem_rdata_IN,
  output logic [15:0] stall_cycles_OUT,
  output logic [15:0] rmw_count_OUT
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_RD} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] rmw_cnt_q, rmw_cnt_d;

  logic        partial_in;
  logic [2:0]  len_in;
  logic        overflow_in;
  logic [31:0] merged_word;

  // Big-endian merge: byte i (byte 0 = bits [31:24]) starting at offset o takes
  // right-justified store byte N-1-(i-o); bytes past the word end are dropped.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [1:0]  off,
                                             input logic [1:0]  sz);
    logic [31:0] res;
    logic [2:0]  n;
    logic [2:0]  o;
    logic [2:0]  k;
    res = old_w;
    n   = (sz == 2'd0) ? 3'd4 : {1'b0, sz};
    o   = {1'b0, off};
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) >= o) && (3'(i) < o + n)) begin
        k = n - 3'd1 - (3'(i) - o);
        res[(3 - i) * 8 +: 8] = new_w[int'(k) * 8 +: 8];
      end
    end
    return res;
  endfunction

  always_comb begin
    partial_in  = (size_IN != 2'd0);
    len_in      = partial_in ? {1'b0, size_IN} : 3'd4;
    overflow_in = partial_in && (({1'b0, addr_IN[1:0]} + len_in) > 3'd4);
    merged_word = merge_word(mem_rdata_IN, wdata_q, addr_q[1:0], size_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of process order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (MemWrite_IN && partial_in) state_d = RMW_RD;
        else if (MemRead_IN && !MemWrite_IN) state_d = RD_WAIT;
      end
      RD_WAIT: state_d = IDLE;
      RMW_RD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata_OUT     = rdata_q;
    stall_OUT     = 1'b0;
    mem_addr_OUT  = 32'h0;
    mem_rd_OUT    = 1'b0;
    mem_wr_OUT    = 1'b0;
    mem_wdata_OUT = 32'h0;
    case (state_q)
      IDLE: begin
        if (MemWrite_IN) begin
          mem_addr_OUT = {addr_IN[31:2], 2'b00};
          if (partial_in) begin
            mem_rd_OUT = 1'b1;
            stall_OUT  = 1'b1;
          end else begin
            mem_wr_OUT    = 1'b1;
            mem_wdata_OUT = wdata_IN;
          end
        end else if (MemRead_IN) begin
          mem_addr_OUT = {addr_IN[31:2], 2'b00};
          mem_rd_OUT   = 1'b1;
          stall_OUT    = 1'b1;
        end
      end
      RD_WAIT: rdata_OUT = mem_rdata_IN;
      RMW_RD: begin
        mem_addr_OUT  = {addr_q[31:2], 2'b00};
        mem_wr_OUT    = 1'b1;
        mem_wdata_OUT = merged_word;
      end
      default: ;
    endcase
    // Reset silences the port immediately, even before the next clock edge.
    if (!RESET) begin
      rdata_OUT     = 32'h0;
      stall_OUT     = 1'b0;
      mem_addr_OUT  = 32'h0;
      mem_rd_OUT    = 1'b0;
      mem_wr_OUT    = 1'b0;
      mem_wdata_OUT = 32'h0;
    end
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    stall_cnt_d = stall_cnt_q;
    rmw_cnt_d   = rmw_cnt_q;
    if (state_q == IDLE && (MemRead_IN || MemWrite_IN)) begin
      addr_d  = addr_IN;
      wdata_d = wdata_IN;
      size_d  = size_IN;
      err_d   = MemWrite_IN && (MemRead_IN || overflow_in);
    end
    if (state_q == RD_WAIT) rdata_d = mem_rdata_IN;
    if (stall_OUT && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (state_q == RMW_RD && rmw_cnt_q != 16'hFFFF) rmw_cnt_d = rmw_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      size_q      <= 2'd0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'h0;
      rmw_cnt_q   <= 16'h0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      rmw_cnt_q   <= rmw_cnt_d;
    end
  end

  assign err_OUT          = err_q;
  assign stall_cycles_OUT = stall_cnt_q;
  assign rmw_count_OUT    = rmw_cnt_q;

endmodule

// File: tb/tb_dmem_rmw_port.sv
// Directed bench for dmem_rmw_port: a small synchronous-read word memory sits behind
// the port, partial stores come from a vector table, corner cases are hand sequences.
module tb_dmem_rmw_port;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] addr_IN, wdata_IN;
  logic [1:0]  size_IN;
  logic        MemRead_IN, MemWrite_IN;
  logic [31:0] rdata_OUT;
  logic        stall_OUT, err_OUT;
  logic [31:0] mem_addr_OUT;
  logic        mem_rd_OUT, mem_wr_OUT;
  logic [31:0] mem_wdata_OUT;
  logic [31:0] mem_rdata_IN;
  logic [15:0] stall_cycles_OUT, rmw_count_OUT;

  dmem_rmw_port dut (
    .CLK(CLK), .RESET(RESET), .addr_IN(addr_IN), .wdata_IN(wdata_IN), .size_IN(size_IN),
    .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .rdata_OUT(rdata_OUT),
    .stall_OUT(stall_OUT), .err_OUT(err_OUT), .mem_addr_OUT(mem_addr_OUT),
    .mem_rd_OUT(mem_rd_OUT), .mem_wr_OUT(mem_wr_OUT), .mem_wdata_OUT(mem_wdata_OUT),
    .mem_rdata_IN(mem_rdata_IN), .stall_cycles_OUT(stall_cycles_OUT),
    .rmw_count_OUT(rmw_count_OUT)
  );

  always #5 CLK = ~CLK;

  // Backing memory: write at the edge, read data registered for the next cycle.
  logic [31:0] mem [0:255];
  initial mem_rdata_IN = 32'h0;
  always @(posedge CLK) begin
    if (mem_wr_OUT) mem[mem_addr_OUT[9:2]] <= mem_wdata_OUT;
    if (mem_rd_OUT) mem_rdata_IN <= mem[mem_addr_OUT[9:2]];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];
  int total = 0;
  int bad = 0;
  int exp_stall = 0;
  int exp_rmw = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    MemRead_IN = 1'b0; MemWrite_IN = 1'b0;
    addr_IN = 32'h0; wdata_IN = 32'h0; size_IN = 2'd0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic both, input logic exp_err);
    @(negedge CLK);
    addr_IN = addr; wdata_IN = data; size_IN = size;
    MemWrite_IN = 1'b1; MemRead_IN = both;
    #1;
    check("st_stall", 32'(stall_OUT), 32'(size != 2'd0));
    check("st_addr", mem_addr_OUT, {addr[31:2], 2'b00});
    if (size != 2'd0) begin
      check("rmw_rd_strobe", {31'h0, mem_rd_OUT}, 32'h1);
      check("rmw_no_wr_first", {31'h0, mem_wr_OUT}, 32'h0);
      exp_stall++;
      @(negedge CLK);
      check("rmw_wr_strobe", {31'h0, mem_wr_OUT}, 32'h1);
      check("rmw_rd_low", {31'h0, mem_rd_OUT}, 32'h0);
      check("rmw_stall_low", {31'h0, stall_OUT}, 32'h0);
      check("rmw_err", {31'h0, err_OUT}, {31'h0, exp_err});
      exp_rmw++;
    end else begin
      check("sw_wr_strobe", {31'h0, mem_wr_OUT}, 32'h1);
      check("sw_wdata", mem_wdata_OUT, data);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge CLK);
    addr_IN = addr; MemRead_IN = 1'b1; MemWrite_IN = 1'b0;
    #1;
    check("ld_stall", {31'h0, stall_OUT}, 32'h1);
    check("ld_rd_strobe", {31'h0, mem_rd_OUT}, 32'h1);
    check("err_single_pulse", {31'h0, err_OUT}, 32'h0);
    exp_stall++;
    @(negedge CLK);
    check("ld_wait_stall", {31'h0, stall_OUT}, 32'h0);
    check("ld_rdata", rdata_OUT, exp);
    check("stall_cycles", {16'h0, stall_cycles_OUT}, 32'(exp_stall));
    check("rmw_count", {16'h0, rmw_count_OUT}, 32'(exp_rmw));
  endtask

  initial begin
    vecs[0] = '{32'h101, 32'h000000AB, 2'd1, 32'h11AB3344, 1'b0};
    vecs[1] = '{32'h102, 32'h0000BEEF, 2'd2, 32'h1122BEEF, 1'b0};
    vecs[2] = '{32'h101, 32'h00A1B2C3, 2'd3, 32'h11A1B2C3, 1'b0};
    vecs[3] = '{32'h100, 32'h00A1B2C3, 2'd3, 32'hA1B2C344, 1'b0};
    vecs[4] = '{32'h103, 32'hDEADBEEF, 2'd0, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{32'h103, 32'h0000BEEF, 2'd2, 32'h112233BE, 1'b1};
    vecs[6] = '{32'h103, 32'h0000005A, 2'd1, 32'h1122335A, 1'b0};
    vecs[7] = '{32'h102, 32'h00CCDDEE, 2'd3, 32'h1122CCDD, 1'b1};
    vecs[8] = '{32'h100, 32'h00007788, 2'd2, 32'h77883344, 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h11223344;

    // Reset with a live request on the inputs: everything must read zero.
    RESET = 1'b0;
    addr_IN = 32'h100; wdata_IN = 32'h0; size_IN = 2'd0;
    MemRead_IN = 1'b1; MemWrite_IN = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_rdata", rdata_OUT, 32'h0);
    check("rst_stall", {31'h0, stall_OUT}, 32'h0);
    check("rst_err", {31'h0, err_OUT}, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd_OUT}, 32'h0);
    check("rst_mem_addr", mem_addr_OUT, 32'h0);
    check("rst_counters", {stall_cycles_OUT, rmw_count_OUT}, 32'h0);
    idle_cycle();
    RESET = 1'b1;

    // Plain load, then the returned word must stay on rdata_OUT while idle.
    do_load(32'h100, 32'h11223344);
    idle_cycle();
    #1;
    check("rdata_held", rdata_OUT, 32'h11223344);

    // Store-then-load to the same word with no gap between them.
    do_store(32'h101, 32'h000000AB, 2'd1, 1'b0, 1'b0);
    do_load(32'h100, 32'h11AB3344);
    check("hazard_mem", mem[64], 32'h11AB3344);

    for (int i = 0; i < 9; i++) begin
      idle_cycle();
      mem[64] = 32'h11223344;
      do_store(vecs[i].addr, vecs[i].wdata, vecs[i].size, 1'b0, vecs[i].exp_err);
      do_load(32'h100, vecs[i].exp_word);
      check($sformatf("vec%0d_word", i), mem[64], vecs[i].exp_word);
    end

    // Read and write together: the store wins and err pulses.
    idle_cycle();
    mem[64] = 32'h11223344;
    do_store(32'h101, 32'h000000AB, 2'd1, 1'b1, 1'b1);
    do_load(32'h100, 32'h11AB3344);

    // Reset during RMW_RD: strobes drop at once and no write lands.
    idle_cycle();
    mem[64] = 32'h11223344;
    @(negedge CLK);
    addr_IN = 32'h101; wdata_IN = 32'h000000AB; size_IN = 2'd1;
    MemWrite_IN = 1'b1; MemRead_IN = 1'b0;
    @(negedge CLK);
    #1;
    check("pre_abort_wr", {31'h0, mem_wr_OUT}, 32'h1);
    RESET = 1'b0;
    #1;
    check("abort_wr", {31'h0, mem_wr_OUT}, 32'h0);
    check("abort_stall", {31'h0, stall_OUT}, 32'h0);
    check("abort_rdata", rdata_OUT, 32'h0);
    check("abort_wdata", mem_wdata_OUT, 32'h0);
    check("abort_counters", {stall_cycles_OUT, rmw_count_OUT}, 32'h0);
    @(negedge CLK);
    check("abort_mem", mem[64], 32'h11223344);
    check("abort_err", {31'h0, err_OUT}, 32'h0);
    idle_cycle();
    RESET = 1'b1;
    exp_stall = 0;
    exp_rmw = 0;
    do_load(32'h100, 32'h11223344);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
